// File: rtl/bool_sweep_pkg.sv
// bool_sweep_pkg: shared FSM encoding and width helpers for the equivalence sweeper
package bool_sweep_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;
   function automatic int cnt_width(input int n_in);
      return n_in + 1;
   endfunction
   function automatic int hold_width(input int settle);
      return (settle < 1) ? 1 : $clog2(settle + 1);
   endfunction
endpackage

// File: rtl/bool_sweep_cmp.sv
// bool_sweep_cmp: per-output mismatch between two implementations and its reduction
module bool_sweep_cmp
   import bool_sweep_pkg::*;
#(
   parameter int N_OUT = 4
) (
   input  logic [N_OUT-1:0] f_a,
   input  logic [N_OUT-1:0] f_b,
   output logic [N_OUT-1:0] mismatch,
   output logic             any_mismatch
);
   assign mismatch     = f_a ^ f_b;
   assign any_mismatch = |mismatch;
endmodule

// File: rtl/bool_equiv_sweeper.sv
// bool_equiv_sweeper: exhaustive A-vs-B truth-table sweep; EQUIV_SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch
module bool_equiv_sweeper
   import bool_sweep_pkg::*;
#(
   parameter int N_IN   = 5,
   parameter int N_OUT  = 4,
   parameter int SETTLE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [N_IN-1:0]  vec,
   input  logic [N_OUT-1:0] f_a,
   input  logic [N_OUT-1:0] f_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_IN:0]    err_count,
   output logic [N_OUT-1:0] err_mask,
   output logic [N_IN-1:0]  first_err_vec,
   output logic             first_err_valid
);
   localparam int CW = cnt_width(N_IN);
   localparam int HW = hold_width(SETTLE);
   localparam logic [HW-1:0] HOLD_LAST = HW'(SETTLE);
   localparam logic [CW-1:0] VEC_LAST  = CW'((1 << N_IN) - 1);
`ifdef EQUIV_SWEEP_STOP_ON_ERR_EN
   localparam bit STOP_ON_ERR = 1'b1;
`else
   localparam bit STOP_ON_ERR = 1'b0;
`endif
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [HW-1:0]    hold;
   logic [N_OUT-1:0] mismatch;
   logic             any_mismatch;
   logic             last;
   bool_sweep_cmp #(.N_OUT(N_OUT)) u_cmp (
      .f_a          (f_a),
      .f_b          (f_b),
      .mismatch     (mismatch),
      .any_mismatch (any_mismatch)
   );
   assign vec  = cnt[N_IN-1:0];
   assign last = (cnt == VEC_LAST) || (STOP_ON_ERR && any_mismatch);
   // FSM, vector/hold counters and result capture; compare happens on the last hold cycle of each vector
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         hold            <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         err_mask        <= '0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state           <= SWEEP;
               cnt             <= '0;
               hold            <= '0;
               busy            <= 1'b1;
               done            <= 1'b0;
               pass            <= 1'b0;
               err_count       <= '0;
               err_mask        <= '0;
               first_err_vec   <= '0;
               first_err_valid <= 1'b0;
            end
            SWEEP: if (hold == HOLD_LAST) begin
               hold <= '0;
               if (any_mismatch) begin
                  err_count <= err_count + 1'b1;
                  err_mask  <= err_mask | mismatch;
                  if (!first_err_valid) begin
                     first_err_vec   <= vec;
                     first_err_valid <= 1'b1;
                  end
               end
               if (last) begin
                  state <= DONE;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !any_mismatch;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end else begin
               hold <= hold + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bool_equiv_sweeper.sv
// tb_bool_equiv_sweeper: scoreboard bench for bool_equiv_sweeper (SETTLE=0 and SETTLE=2 instances)
module tb_bool_equiv_sweeper;
   logic       clk = 1'b0;
   logic       reset = 1'b1, start = 1'b0, start2 = 1'b0;
   logic [4:0] vec, vec2, first_err_vec, fev2;
   logic [3:0] f_a, f_b, f_a2, f_b2, err_mask, err_mask2;
   logic [5:0] err_count, err_count2;
   logic       busy, done, pass, first_err_valid;
   logic       busy2, done2, pass2, fevv2;
   logic [4:0] fv0 = '0, fv1 = '0;
   logic [3:0] fm0 = '0, fm1 = '0;
   logic [4:0] exp_q[$];
   int         tests = 0, fails = 0;

   always #5 clk = ~clk;

   function automatic logic [3:0] fn(input logic [4:0] v);
      return {v[4] ^ v[0], v[3] & v[1], v[2] | v[4], ~v[1]};
   endfunction

   function automatic logic [3:0] inj(input logic [4:0] v);
      return ((v == fv0) ? fm0 : 4'd0) | ((v == fv1) ? fm1 : 4'd0);
   endfunction

   assign f_a  = fn(vec);
   assign f_b  = f_a ^ (((vec == fv0) ? fm0 : 4'd0) | ((vec == fv1) ? fm1 : 4'd0));
   assign f_a2 = fn(vec2);
   assign f_b2 = f_a2;

   bool_equiv_sweeper #(.N_IN(5), .N_OUT(4), .SETTLE(0)) dut (
      .clk(clk), .reset(reset), .start(start), .vec(vec), .f_a(f_a), .f_b(f_b),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .err_mask(err_mask),
      .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
   );

   bool_equiv_sweeper #(.N_IN(5), .N_OUT(4), .SETTLE(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .vec(vec2), .f_a(f_a2), .f_b(f_b2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2), .err_mask(err_mask2),
      .first_err_vec(fev2), .first_err_valid(fevv2)
   );

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (pass !== 1'b0) begin fails++; $display("FAIL reset_pass: got %b want 0", pass); end
      tests++; if (vec !== 5'd0) begin fails++; $display("FAIL reset_vec: got %0d want 0", vec); end
      tests++; if (err_count !== 6'd0) begin fails++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      tests++; if (err_mask !== 4'd0) begin fails++; $display("FAIL reset_err_mask: got %b want 0000", err_mask); end
      tests++; if ({first_err_valid, first_err_vec} !== 6'd0) begin fails++; $display("FAIL reset_first_err: got %b/%0d want 0/0", first_err_valid, first_err_vec); end
      tests++; if ({busy2, done2, pass2, vec2} !== 8'd0) begin fails++; $display("FAIL reset_dut2: got %b want 0", {busy2, done2, pass2, vec2}); end
   endtask

   task automatic run_sweep(input string name);
      int ecnt, n;
      logic [3:0] emask;
      logic [4:0] efv, v;
      logic efvv;
      exp_q.delete();
      ecnt = 0; emask = '0; efv = '0; efvv = 1'b0;
      for (int k = 0; k < 32; k++) begin
         v = k[4:0];
         exp_q.push_back(v);
         if (inj(v) != 4'd0) begin
            ecnt++;
            emask |= inj(v);
            if (!efvv) begin efv = v; efvv = 1'b1; end
`ifdef EQUIV_SWEEP_STOP_ON_ERR_EN
            break;
`endif
         end
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL %s_start_edge: got busy=%b done=%b want 1/0", name, busy, done); end
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         tests++;
         if (exp_q.size() == 0) begin fails++; $display("FAIL %s_extra_vec: got %0d want none", name, vec); end
         else begin
            v = exp_q.pop_front();
            if (vec !== v) begin fails++; $display("FAIL %s_vec: got %0d want %0d", name, vec, v); end
         end
         n++;
         @(negedge clk);
      end
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL %s_missing_vecs: got %0d left want 0", name, exp_q.size()); end
      tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL %s_done: got done=%b busy=%b want 1/0", name, done, busy); end
      tests++; if (pass !== (ecnt == 0)) begin fails++; $display("FAIL %s_pass: got %b want %b", name, pass, ecnt == 0); end
      tests++; if (err_count !== 6'(ecnt)) begin fails++; $display("FAIL %s_err_count: got %0d want %0d", name, err_count, ecnt); end
      tests++; if (err_mask !== emask) begin fails++; $display("FAIL %s_err_mask: got %b want %b", name, err_mask, emask); end
      tests++; if (first_err_valid !== efvv || first_err_vec !== efv) begin fails++; $display("FAIL %s_first_err: got %b/%0d want %b/%0d", name, first_err_valid, first_err_vec, efvv, efv); end
      tests++; if (vec !== 5'd0) begin fails++; $display("FAIL %s_done_vec: got %0d want 0", name, vec); end
   endtask

   task automatic test_equal();
      fv0 = 5'd0; fm0 = 4'd0; fv1 = 5'd0; fm1 = 4'd0;
      run_sweep("equal");
   endtask

   task automatic test_single_err();
      fv0 = 5'd19; fm0 = 4'b0100; fv1 = 5'd0; fm1 = 4'd0;
      run_sweep("single");
   endtask

   task automatic test_double_err();
      fv0 = 5'd3; fm0 = 4'b0001; fv1 = 5'd30; fm1 = 4'b1000;
      run_sweep("double");
   endtask

   task automatic test_settle();
      logic [4:0] q2[$];
      logic [4:0] v;
      int n;
      for (int k = 0; k < 32; k++) repeat (3) q2.push_back(5'(k));
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (busy2 === 1'b1 && n < 400) begin
         tests++;
         if (q2.size() == 0) begin fails++; $display("FAIL settle_extra_vec: got %0d want none", vec2); end
         else begin
            v = q2.pop_front();
            if (vec2 !== v) begin fails++; $display("FAIL settle_vec: got %0d want %0d", vec2, v); end
         end
         n++;
         @(negedge clk);
      end
      tests++; if (n != 96) begin fails++; $display("FAIL settle_cycles: got %0d want 96", n); end
      tests++; if (done2 !== 1'b1 || pass2 !== 1'b1) begin fails++; $display("FAIL settle_done_pass: got %b/%b want 1/1", done2, pass2); end
      tests++; if (err_count2 !== 6'd0 || err_mask2 !== 4'd0 || fevv2 !== 1'b0) begin fails++; $display("FAIL settle_errs: got %0d/%b/%b want 0/0000/0", err_count2, err_mask2, fevv2); end
   endtask

   task automatic test_back_to_back();
      int n;
      fv0 = 5'd0; fm0 = 4'd0; fv1 = 5'd0; fm1 = 4'd0;
      start = 1'b1;
      @(negedge clk);
      n = 0;
      while (done !== 1'b1 && n < 100) begin n++; @(negedge clk); end
      tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL b2b_first_done: got done=%b busy=%b want 1/0", done, busy); end
      @(negedge clk);
      tests++; if (busy !== 1'b1 || done !== 1'b0 || vec !== 5'd0) begin fails++; $display("FAIL b2b_restart: got busy=%b done=%b vec=%0d want 1/0/0", busy, done, vec); end
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 100) begin n++; @(negedge clk); end
      tests++; if (done !== 1'b1 || pass !== 1'b1) begin fails++; $display("FAIL b2b_second_done: got done=%b pass=%b want 1/1", done, pass); end
   endtask

   task automatic test_ignore_and_reset();
      int n;
      fv0 = 5'd2; fm0 = 4'b0010; fv1 = 5'd0; fm1 = 4'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (vec !== 5'd5 && n < 100) begin n++; @(negedge clk); end
      tests++; if (vec !== 5'd5) begin fails++; $display("FAIL ignore_reach5: got %0d want 5", vec); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++; if (busy !== 1'b1 || vec !== 5'd6) begin fails++; $display("FAIL ignore_start: got busy=%b vec=%0d want 1/6", busy, vec); end
      n = 0;
      while (vec !== 5'd10 && n < 100) begin n++; @(negedge clk); end
      tests++; if (vec !== 5'd10 || err_count !== 6'd1) begin fails++; $display("FAIL ignore_reach10: got vec=%0d errs=%0d want 10/1", vec, err_count); end
      #2 reset = 1'b1;
      #1;
      tests++; if ({vec, busy, done, pass, err_count, err_mask, first_err_vec, first_err_valid} !== '0) begin fails++; $display("FAIL midreset_clear: got vec=%0d busy=%b done=%b errs=%0d mask=%b fev=%b/%0d want all 0", vec, busy, done, err_count, err_mask, first_err_valid, first_err_vec); end
      #1 reset = 1'b0;
      @(negedge clk);
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midreset_idle: got busy=%b done=%b want 0/0", busy, done); end
      fv0 = 5'd19; fm0 = 4'b0100;
      run_sweep("after_reset");
   endtask

   initial begin
      test_reset();
      test_equal();
      test_single_err();
      test_double_err();
      test_settle();
      test_back_to_back();
      test_ignore_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
